// File: rtl/bpred_pkg.sv
// Shared branch-predictor definitions: 2-bit counter encodings, scheduler
// states and the saturating counter update.
package bpred_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [1:0] CTR_INIT = WT;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } sched_state_e;

  // Saturating step of a 2-bit counter towards the resolved direction
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    case (ctr)
      SNT:     res = taken ? WNT : SNT;
      WNT:     res = taken ? WT  : SNT;
      WT:      res = taken ? ST  : WNT;
      ST:      res = taken ? ST  : WT;
      default: res = ctr;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pht_access_scheduler_if.sv
// Pipeline-side lookup/update handshakes plus the single PHT RAM port.
interface pht_access_scheduler_if #(
  parameter int unsigned BPRED_WIDTH = 10
);
  logic                   i_Lookup_Valid;
  logic [BPRED_WIDTH-1:0] i_Lookup_Index;
  logic                   o_Lookup_Stall;
  logic                   o_Pred_Valid;
  logic                   o_Prediction;
  logic [1:0]             o_Pred_Counter;
  logic                   i_Update_Valid;
  logic [BPRED_WIDTH-1:0] i_Update_Index;
  logic [1:0]             i_Update_Counter;
  logic                   i_Update_Outcome;
  logic                   o_Update_Drop;
  logic                   o_PHT_En;
  logic                   o_PHT_We;
  logic [BPRED_WIDTH-1:0] o_PHT_Addr;
  logic [1:0]             o_PHT_Wdata;
  logic [1:0]             i_PHT_Rdata;
  logic                   o_Init_Done;

  modport slave (
    input  i_Lookup_Valid, i_Lookup_Index,
    input  i_Update_Valid, i_Update_Index, i_Update_Counter, i_Update_Outcome,
    input  i_PHT_Rdata,
    output o_Lookup_Stall, o_Pred_Valid, o_Prediction, o_Pred_Counter,
    output o_Update_Drop, o_PHT_En, o_PHT_We, o_PHT_Addr, o_PHT_Wdata, o_Init_Done
  );

  modport master (
    output i_Lookup_Valid, i_Lookup_Index,
    output i_Update_Valid, i_Update_Index, i_Update_Counter, i_Update_Outcome,
    output i_PHT_Rdata,
    input  o_Lookup_Stall, o_Pred_Valid, o_Prediction, o_Pred_Counter,
    input  o_Update_Drop, o_PHT_En, o_PHT_We, o_PHT_Addr, o_PHT_Wdata, o_Init_Done
  );
endinterface

// File: rtl/bpred_update_queue.sv
// Circular FIFO of pending PHT writes {index, new counter} with a
// youngest-entry match search used for lookup bypass.
module bpred_update_queue #(
  parameter int unsigned IW    = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [IW-1:0] push_idx,
  input  logic [1:0]    push_val,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [IW-1:0] head_idx,
  output logic [1:0]    head_val,
  input  logic [IW-1:0] search_idx,
  output logic          hit,
  output logic [1:0]    hit_val
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [IW-1:0] idx_mem [DEPTH];
  logic [1:0]    val_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;
  logic [PW-1:0] slot;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A full queue still accepts a push when the head leaves the same cycle
  assign do_push  = push && (!full || do_pop);
  assign head_idx = idx_mem[rd_ptr];
  assign head_val = val_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      idx_mem[wr_ptr] <= push_idx;
      val_mem[wr_ptr] <= push_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Walk oldest to youngest so the last match wins
  always_comb begin
    hit     = 1'b0;
    hit_val = 2'b00;
    slot    = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      slot = rd_ptr + PW'(k);
      if ((CW'(k) < count) && (idx_mem[slot] == search_idx)) begin
        hit     = 1'b1;
        hit_val = val_mem[slot];
      end
    end
  end

endmodule

// File: rtl/pht_access_scheduler.sv
// Single-port PHT arbiter: post-reset weakly-taken sweep, lookups with
// queued-update bypass, and update writes drained into idle or forced slots.
module pht_access_scheduler
  import bpred_pkg::*;
#(
  parameter int unsigned BPRED_WIDTH  = 10,
  parameter int unsigned UQ_DEPTH     = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic                   i_Clk,
  input logic                   i_Reset,
  pht_access_scheduler_if.slave bus
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  sched_state_e           state;
  sched_state_e           state_nxt;
  logic [BPRED_WIDTH-1:0] init_addr;
  logic [SW-1:0]          starve;

  logic                   q_full;
  logic                   q_empty;
  logic [BPRED_WIDTH-1:0] head_idx;
  logic [1:0]             head_val;
  logic                   hit;
  logic [1:0]             hit_val;

  logic                   force_wr;
  logic                   lookup_go;
  logic                   wr;
  logic                   stall;
  logic                   pht_en;
  logic                   pht_we;
  logic [BPRED_WIDTH-1:0] pht_addr;
  logic [1:0]             pht_wdata;

  logic                   pred_valid_q;
  logic                   byp_hit_q;
  logic [1:0]             byp_val_q;
  logic                   drop_q;
  logic [1:0]             pred_ctr;

  bpred_update_queue #(
    .IW    (BPRED_WIDTH),
    .DEPTH (UQ_DEPTH)
  ) u_queue (
    .clk        (i_Clk),
    .rst_n      (i_Reset),
    .push       ((state == RUN) && bus.i_Update_Valid),
    .push_idx   (bus.i_Update_Index),
    .push_val   (sat_update(bus.i_Update_Counter, bus.i_Update_Outcome)),
    .pop        (wr),
    .full       (q_full),
    .empty      (q_empty),
    .head_idx   (head_idx),
    .head_val   (head_val),
    .search_idx (bus.i_Lookup_Index),
    .hit        (hit),
    .hit_val    (hit_val)
  );

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) state <= INIT;
    else          state <= state_nxt;
  end

  // Next state and per-cycle port arbitration
  always_comb begin
    state_nxt = state;
    force_wr  = !q_empty && (q_full || (starve == SW'(STARVE_LIMIT)));
    lookup_go = 1'b0;
    wr        = 1'b0;
    stall     = 1'b0;
    pht_en    = 1'b0;
    pht_we    = 1'b0;
    pht_addr  = '0;
    pht_wdata = SNT;
    case (state)
      INIT: begin
        stall     = bus.i_Lookup_Valid;
        pht_en    = 1'b1;
        pht_we    = 1'b1;
        pht_addr  = init_addr;
        pht_wdata = CTR_INIT;
        if (init_addr == {BPRED_WIDTH{1'b1}}) state_nxt = RUN;
      end
      RUN: begin
        wr        = force_wr || (!bus.i_Lookup_Valid && !q_empty);
        lookup_go = bus.i_Lookup_Valid && !force_wr;
        stall     = bus.i_Lookup_Valid && force_wr;
        if (wr) begin
          pht_en    = 1'b1;
          pht_we    = 1'b1;
          pht_addr  = head_idx;
          pht_wdata = head_val;
        end else if (lookup_go) begin
          pht_en    = 1'b1;
          pht_addr  = bus.i_Lookup_Index;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      init_addr    <= '0;
      starve       <= '0;
      pred_valid_q <= 1'b0;
      byp_hit_q    <= 1'b0;
      byp_val_q    <= SNT;
      drop_q       <= 1'b0;
    end else begin
      if (state == INIT) init_addr <= init_addr + BPRED_WIDTH'(1);
      if (wr)                         starve <= '0;
      else if (lookup_go && !q_empty) starve <= starve + SW'(1);
      pred_valid_q <= lookup_go;
      if (lookup_go) begin
        byp_hit_q <= hit;
        byp_val_q <= hit_val;
      end
      drop_q <= (state == INIT) && bus.i_Update_Valid;
    end
  end

  // A queued match overrides the RAM read in the result cycle
  assign pred_ctr = !pred_valid_q ? SNT : (byp_hit_q ? byp_val_q : bus.i_PHT_Rdata);

  assign bus.o_Lookup_Stall = stall;
  assign bus.o_Pred_Valid   = pred_valid_q;
  assign bus.o_Prediction   = pred_ctr[1];
  assign bus.o_Pred_Counter = pred_ctr;
  assign bus.o_Update_Drop  = drop_q;
  assign bus.o_PHT_En       = pht_en;
  assign bus.o_PHT_We       = pht_we;
  assign bus.o_PHT_Addr     = pht_addr;
  assign bus.o_PHT_Wdata    = pht_wdata;
  assign bus.o_Init_Done    = (state == RUN);

endmodule
